// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Holds the FSM states, the access-width encodings, the port-select enum and the starvation default.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W           = 32;
  localparam int unsigned DATA_W           = 32;
  localparam int unsigned WIDTH_W          = 2;
  localparam int unsigned CNT_W            = 2;
  localparam int unsigned STARVE_LIMIT_DEF = 3;

  localparam logic [WIDTH_W-1:0] WIDTH_BYTE = 2'd0;
  localparam logic [WIDTH_W-1:0] WIDTH_HALF = 2'd1;
  localparam logic [WIDTH_W-1:0] WIDTH_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    SEL_DATA = 1'b0,
    SEL_INST = 1'b1
  } port_sel_t;

  // Command presented on the shared memory port.
  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  wdata;
    logic               we;
    logic [WIDTH_W-1:0] width;
    logic               zeroextend;
  } mem_cmd_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (value == {CNT_W{1'b1}}) ? value : value + CNT_W'(1);
  endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Priority and starvation decision: data normally wins, but a waiting
// instruction fetch is forced through once it has lost STARVE_LIMIT times.
module arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic             inst_req,
  input  logic             data_req,
  input  logic [CNT_W-1:0] count,
  output port_sel_t        sel_c,
  output logic [CNT_W-1:0] next_count_c
);

  always_comb begin
    sel_c        = SEL_DATA;
    next_count_c = count;
    if (inst_req && (count == CNT_W'(STARVE_LIMIT))) begin
      sel_c        = SEL_INST;
      next_count_c = '0;
    end else if (data_req) begin
      sel_c = SEL_DATA;
      // Only a data win that leaves a fetch waiting counts as a loss.
      if (inst_req) begin
        next_count_c = sat_inc(count);
      end
    end else if (inst_req) begin
      sel_c        = SEL_INST;
      next_count_c = '0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a load/store port onto one
// memory port; one transaction at a time, IDLE -> BUSY -> RESP.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_inst_req,
  input  logic [ADDR_W-1:0]  i_inst_addr,
  output logic               o_inst_ack,
  output logic [DATA_W-1:0]  o_inst_rdata,
  input  logic               i_data_req,
  input  logic [ADDR_W-1:0]  i_data_addr,
  input  logic [DATA_W-1:0]  i_data_wdata,
  input  logic               i_data_we,
  input  logic [WIDTH_W-1:0] i_data_width,
  input  logic               i_data_zeroextend,
  output logic               o_data_ack,
  output logic [DATA_W-1:0]  o_data_rdata,
  output logic               o_mem_req,
  output logic [ADDR_W-1:0]  o_mem_addr,
  output logic [DATA_W-1:0]  o_mem_wdata,
  output logic               o_mem_we,
  output logic [WIDTH_W-1:0] o_mem_width,
  output logic               o_mem_zeroextend,
  input  logic               i_mem_ack,
  input  logic [DATA_W-1:0]  i_mem_rdata
);

  state_t            state, state_nxt;
  port_sel_t         sel, sel_nxt, pick_sel;
  logic [CNT_W-1:0]  count, count_nxt, pick_count;
  mem_cmd_t          cmd, cmd_nxt, inst_cmd, data_cmd;
  logic              mem_req, mem_req_nxt;
  logic              inst_ack, inst_ack_nxt;
  logic              data_ack, data_ack_nxt;
  logic [DATA_W-1:0] inst_rdata, inst_rdata_nxt;
  logic [DATA_W-1:0] data_rdata, data_rdata_nxt;

  arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb_pick (
    .inst_req     (i_inst_req),
    .data_req     (i_data_req),
    .count        (count),
    .sel_c        (pick_sel),
    .next_count_c (pick_count)
  );

  // Fetches are always plain word reads.
  always_comb begin
    inst_cmd            = '0;
    inst_cmd.addr       = i_inst_addr;
    inst_cmd.we         = 1'b0;
    inst_cmd.width      = WIDTH_WORD;
    inst_cmd.zeroextend = 1'b0;

    data_cmd            = '0;
    data_cmd.addr       = i_data_addr;
    data_cmd.wdata      = i_data_wdata;
    data_cmd.we         = i_data_we;
    data_cmd.width      = i_data_width;
    data_cmd.zeroextend = i_data_zeroextend;
  end

  always_comb begin
    state_nxt      = state;
    sel_nxt        = sel;
    count_nxt      = count;
    cmd_nxt        = cmd;
    mem_req_nxt    = mem_req;
    inst_ack_nxt   = 1'b0;
    data_ack_nxt   = 1'b0;
    inst_rdata_nxt = inst_rdata;
    data_rdata_nxt = data_rdata;

    case (state)
      IDLE: begin
        if (i_inst_req || i_data_req) begin
          sel_nxt     = pick_sel;
          count_nxt   = pick_count;
          cmd_nxt     = (pick_sel == SEL_INST) ? inst_cmd : data_cmd;
          mem_req_nxt = 1'b1;
          state_nxt   = BUSY;
        end
      end
      BUSY: begin
        if (i_mem_ack) begin
          mem_req_nxt = 1'b0;
          if (sel == SEL_INST) begin
            inst_ack_nxt   = 1'b1;
            inst_rdata_nxt = i_mem_rdata;
          end else begin
            data_ack_nxt   = 1'b1;
            data_rdata_nxt = i_mem_rdata;
          end
          state_nxt = RESP;
        end
      end
      // Ack is visible for this one cycle; requesters drop req before the next IDLE sample.
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt   = IDLE;
        mem_req_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      sel        <= SEL_DATA;
      count      <= '0;
      cmd        <= '0;
      mem_req    <= 1'b0;
      inst_ack   <= 1'b0;
      data_ack   <= 1'b0;
      inst_rdata <= '0;
      data_rdata <= '0;
    end else begin
      state      <= state_nxt;
      sel        <= sel_nxt;
      count      <= count_nxt;
      cmd        <= cmd_nxt;
      mem_req    <= mem_req_nxt;
      inst_ack   <= inst_ack_nxt;
      data_ack   <= data_ack_nxt;
      inst_rdata <= inst_rdata_nxt;
      data_rdata <= data_rdata_nxt;
    end
  end

  assign o_mem_req        = mem_req;
  assign o_mem_addr       = cmd.addr;
  assign o_mem_wdata      = cmd.wdata;
  assign o_mem_we         = cmd.we;
  assign o_mem_width      = cmd.width;
  assign o_mem_zeroextend = cmd.zeroextend;
  assign o_inst_ack       = inst_ack;
  assign o_inst_rdata     = inst_rdata;
  assign o_data_ack       = data_ack;
  assign o_data_rdata     = data_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: one task per scenario,
// expected values written out by hand from the arbiter's behaviour.
module tb_mem_arbiter;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_inst_req;
  logic [31:0] i_inst_addr;
  logic        o_inst_ack;
  logic [31:0] o_inst_rdata;
  logic        i_data_req;
  logic [31:0] i_data_addr;
  logic [31:0] i_data_wdata;
  logic        i_data_we;
  logic [1:0]  i_data_width;
  logic        i_data_zeroextend;
  logic        o_data_ack;
  logic [31:0] o_data_rdata;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        o_mem_we;
  logic [1:0]  o_mem_width;
  logic        o_mem_zeroextend;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;

  int checks = 0;
  int errors = 0;
  int inst_acks = 0;
  int data_acks = 0;

  mem_arbiter #(.STARVE_LIMIT(3)) dut (
    .i_clk             (i_clk),
    .i_rst_n           (i_rst_n),
    .i_inst_req        (i_inst_req),
    .i_inst_addr       (i_inst_addr),
    .o_inst_ack        (o_inst_ack),
    .o_inst_rdata      (o_inst_rdata),
    .i_data_req        (i_data_req),
    .i_data_addr       (i_data_addr),
    .i_data_wdata      (i_data_wdata),
    .i_data_we         (i_data_we),
    .i_data_width      (i_data_width),
    .i_data_zeroextend (i_data_zeroextend),
    .o_data_ack        (o_data_ack),
    .o_data_rdata      (o_data_rdata),
    .o_mem_req         (o_mem_req),
    .o_mem_addr        (o_mem_addr),
    .o_mem_wdata       (o_mem_wdata),
    .o_mem_we          (o_mem_we),
    .o_mem_width       (o_mem_width),
    .o_mem_zeroextend  (o_mem_zeroextend),
    .i_mem_ack         (i_mem_ack),
    .i_mem_rdata       (i_mem_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Running tally of ack pulses, used for "exactly one ack" style checks.
  always @(posedge i_clk) begin
    if (o_inst_ack === 1'b1) inst_acks <= inst_acks + 1;
    if (o_data_ack === 1'b1) data_acks <= data_acks + 1;
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Memory model: wait (bounded) for o_mem_req, stall lat cycles, pulse ack.
  task automatic serve(input int lat, input logic [31:0] rd, output bit seen,
                       output logic [31:0] addr, output logic we);
    int n = 0;
    seen = 1'b0;
    addr = '0;
    we   = 1'b0;
    while (o_mem_req !== 1'b1 && n < 16) begin
      step();
      n++;
    end
    if (o_mem_req === 1'b1) begin
      seen = 1'b1;
      addr = o_mem_addr;
      we   = o_mem_we;
      repeat (lat) step();
      i_mem_ack   = 1'b1;
      i_mem_rdata = rd;
      step();
      i_mem_ack   = 1'b0;
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_mem_ack = 1'b1;
    i_mem_rdata = 32'hFFFF_FFFF;
    step();
    step();
    checks++;
    if ({o_mem_req, o_inst_ack, o_data_ack} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: got req/iack/dack=%b, want 000", {o_mem_req, o_inst_ack, o_data_ack});
    end
    checks++;
    if (o_mem_addr !== 32'h0 || o_mem_wdata !== 32'h0 || o_mem_we !== 1'b0 ||
        o_mem_width !== 2'd0 || o_mem_zeroextend !== 1'b0) begin
      errors++;
      $display("FAIL reset_mem_fields: got addr=%h wdata=%h we=%b width=%0d ze=%b, want all 0",
               o_mem_addr, o_mem_wdata, o_mem_we, o_mem_width, o_mem_zeroextend);
    end
    checks++;
    if (o_inst_rdata !== 32'h0 || o_data_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: got inst=%h data=%h, want 0/0", o_inst_rdata, o_data_rdata);
    end
    i_mem_ack = 1'b0;
    i_rst_n = 1'b1;
    step();
  endtask

  task automatic test_inst_fetch();
    int a0 = inst_acks;
    int d0 = data_acks;
    i_inst_req  = 1'b1;
    i_inst_addr = 32'h1000_0000;
    step();
    checks++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h1000_0000 || o_mem_we !== 1'b0 ||
        o_mem_width !== 2'd2 || o_mem_zeroextend !== 1'b0) begin
      errors++;
      $display("FAIL inst_grant: got req=%b addr=%h we=%b width=%0d ze=%b, want 1 10000000 0 2 0",
               o_mem_req, o_mem_addr, o_mem_we, o_mem_width, o_mem_zeroextend);
    end
    step();
    checks++;
    if (o_inst_ack !== 1'b0) begin
      errors++;
      $display("FAIL inst_ack_early: got %b, want 0", o_inst_ack);
    end
    i_mem_ack   = 1'b1;
    i_mem_rdata = 32'h0000_0013;
    step();
    i_mem_ack = 1'b0;
    checks++;
    if (o_inst_ack !== 1'b1 || o_inst_rdata !== 32'h0000_0013 || o_data_ack !== 1'b0 || o_mem_req !== 1'b0) begin
      errors++;
      $display("FAIL inst_turnaround: got iack=%b rdata=%h dack=%b req=%b, want 1 00000013 0 0",
               o_inst_ack, o_inst_rdata, o_data_ack, o_mem_req);
    end
    i_inst_req = 1'b0;
    step();
    checks++;
    if (o_inst_ack !== 1'b0 || o_inst_rdata !== 32'h0000_0013) begin
      errors++;
      $display("FAIL inst_rdata_hold: got iack=%b rdata=%h, want 0 00000013", o_inst_ack, o_inst_rdata);
    end
    step();
    checks++;
    if (inst_acks - a0 !== 1 || data_acks - d0 !== 0 || o_mem_req !== 1'b0) begin
      errors++;
      $display("FAIL inst_ack_count: got inst=%0d data=%0d req=%b, want 1 0 0",
               inst_acks - a0, data_acks - d0, o_mem_req);
    end
  endtask

  task automatic test_simultaneous();
    int a0 = inst_acks;
    int d0 = data_acks;
    i_data_req = 1'b1; i_data_addr = 32'h0000_0020; i_data_wdata = 32'hDEAD_BEEF;
    i_data_we = 1'b1; i_data_width = 2'd2; i_data_zeroextend = 1'b0;
    i_inst_req = 1'b1; i_inst_addr = 32'h0000_0100;
    step();
    checks++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h20 || o_mem_wdata !== 32'hDEAD_BEEF ||
        o_mem_we !== 1'b1 || o_mem_width !== 2'd2) begin
      errors++;
      $display("FAIL sim_data_first: got req=%b addr=%h wdata=%h we=%b width=%0d, want 1 20 deadbeef 1 2",
               o_mem_req, o_mem_addr, o_mem_wdata, o_mem_we, o_mem_width);
    end
    step();
    i_mem_ack = 1'b1; i_mem_rdata = 32'h1234_5678;
    step();
    i_mem_ack = 1'b0;
    checks++;
    if (o_data_ack !== 1'b1 || o_inst_ack !== 1'b0 || o_data_rdata !== 32'h1234_5678 || o_inst_rdata !== 32'h13) begin
      errors++;
      $display("FAIL sim_data_ack: got dack=%b iack=%b drdata=%h irdata=%h, want 1 0 12345678 00000013",
               o_data_ack, o_inst_ack, o_data_rdata, o_inst_rdata);
    end
    i_data_req = 1'b0; i_data_we = 1'b0;
    step();
    checks++;
    if (o_mem_req !== 1'b0 || o_data_ack !== 1'b0) begin
      errors++;
      $display("FAIL sim_resp_gap: got req=%b dack=%b, want 0 0", o_mem_req, o_data_ack);
    end
    step();
    checks++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h100 || o_mem_we !== 1'b0 ||
        o_mem_width !== 2'd2 || o_mem_zeroextend !== 1'b0) begin
      errors++;
      $display("FAIL sim_inst_second: got req=%b addr=%h we=%b width=%0d ze=%b, want 1 100 0 2 0",
               o_mem_req, o_mem_addr, o_mem_we, o_mem_width, o_mem_zeroextend);
    end
    step();
    i_mem_ack = 1'b1; i_mem_rdata = 32'h0000_0093;
    step();
    i_mem_ack = 1'b0;
    checks++;
    if (o_inst_ack !== 1'b1 || o_data_ack !== 1'b0 || o_inst_rdata !== 32'h93) begin
      errors++;
      $display("FAIL sim_inst_ack: got iack=%b dack=%b rdata=%h, want 1 0 00000093",
               o_inst_ack, o_data_ack, o_inst_rdata);
    end
    i_inst_req = 1'b0;
    step();
    step();
    checks++;
    if (inst_acks - a0 !== 1 || data_acks - d0 !== 1 || o_mem_req !== 1'b0) begin
      errors++;
      $display("FAIL sim_ack_count: got inst=%0d data=%0d req=%b, want 1 1 0",
               inst_acks - a0, data_acks - d0, o_mem_req);
    end
  endtask

  task automatic test_starvation();
    logic [6:0]  exp_inst = 7'b1001000;
    int          nd = 0;
    int          ni = 0;
    bit          seen;
    logic [31:0] addr;
    logic        we;
    logic        want_inst;
    logic [31:0] want_addr;
    i_data_req = 1'b1; i_data_we = 1'b0; i_data_width = 2'd2; i_data_zeroextend = 1'b0;
    i_data_addr = 32'h0000_1000;
    i_inst_req = 1'b1; i_inst_addr = 32'h0000_2000;
    for (int g = 0; g < 7; g++) begin
      want_inst = exp_inst[g];
      want_addr = want_inst ? 32'h2000 + 32'(4 * ni) : 32'h1000 + 32'(4 * nd);
      serve(1, 32'h5000 + 32'(g), seen, addr, we);
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL starve_timeout: grant %0d got no o_mem_req within 16 cycles", g);
      end else if (o_inst_ack !== want_inst || o_data_ack !== !want_inst || addr !== want_addr ||
                   (want_inst && we !== 1'b0)) begin
        errors++;
        $display("FAIL starve_grant: grant %0d got iack=%b dack=%b addr=%h we=%b, want iack=%b addr=%h",
                 g, o_inst_ack, o_data_ack, addr, we, want_inst, want_addr);
      end
      if (want_inst) begin
        ni++;
        i_inst_addr = 32'h2000 + 32'(4 * ni);
      end else begin
        nd++;
        i_data_addr = 32'h1000 + 32'(4 * nd);
        if (nd == 5) i_data_req = 1'b0;
      end
    end
    i_inst_req = 1'b0;
    checks++;
    if (o_inst_rdata !== 32'h0000_5006 || o_data_rdata !== 32'h0000_5005) begin
      errors++;
      $display("FAIL starve_rdata: got inst=%h data=%h, want 00005006 00005005", o_inst_rdata, o_data_rdata);
    end
    step();
    step();
  endtask

  task automatic test_byte_load_stall();
    i_data_req = 1'b1; i_data_addr = 32'h0000_0033; i_data_we = 1'b0;
    i_data_width = 2'd0; i_data_zeroextend = 1'b1;
    step();
    checks++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h33 || o_mem_width !== 2'd0 ||
        o_mem_zeroextend !== 1'b1 || o_mem_we !== 1'b0) begin
      errors++;
      $display("FAIL byte_grant: got req=%b addr=%h width=%0d ze=%b we=%b, want 1 33 0 1 0",
               o_mem_req, o_mem_addr, o_mem_width, o_mem_zeroextend, o_mem_we);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h33 || o_mem_width !== 2'd0 ||
          o_mem_zeroextend !== 1'b1 || o_data_ack !== 1'b0) begin
        errors++;
        $display("FAIL byte_stall_stable: cycle %0d got req=%b addr=%h width=%0d ze=%b dack=%b, want 1 33 0 1 0",
                 i, o_mem_req, o_mem_addr, o_mem_width, o_mem_zeroextend, o_data_ack);
      end
    end
    i_mem_ack = 1'b1; i_mem_rdata = 32'h0000_00AB;
    step();
    i_mem_ack = 1'b0;
    checks++;
    if (o_data_ack !== 1'b1 || o_data_rdata !== 32'hAB || o_mem_req !== 1'b0) begin
      errors++;
      $display("FAIL byte_ack: got dack=%b rdata=%h req=%b, want 1 000000ab 0", o_data_ack, o_data_rdata, o_mem_req);
    end
    i_data_req = 1'b0; i_data_zeroextend = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset_busy();
    int          a0;
    int          d0;
    bit          seen;
    logic [31:0] addr;
    logic        we;
    i_data_req = 1'b1; i_data_addr = 32'h0000_0044; i_data_wdata = 32'h0000_0055;
    i_data_we = 1'b1; i_data_width = 2'd1;
    step();
    checks++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h44) begin
      errors++;
      $display("FAIL rst_busy_grant: got req=%b addr=%h, want 1 44", o_mem_req, o_mem_addr);
    end
    i_rst_n = 1'b0;
    i_data_req = 1'b0; i_data_we = 1'b0;
    step();
    checks++;
    if (o_mem_req !== 1'b0 || o_inst_ack !== 1'b0 || o_data_ack !== 1'b0 || o_mem_addr !== 32'h0 ||
        o_mem_wdata !== 32'h0 || o_mem_we !== 1'b0 || o_mem_width !== 2'd0 ||
        o_inst_rdata !== 32'h0 || o_data_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_busy_clear: got req=%b addr=%h wdata=%h we=%b width=%0d irdata=%h drdata=%h, want all 0",
               o_mem_req, o_mem_addr, o_mem_wdata, o_mem_we, o_mem_width, o_inst_rdata, o_data_rdata);
    end
    i_rst_n = 1'b1;
    a0 = inst_acks;
    d0 = data_acks;
    i_mem_ack = 1'b1; i_mem_rdata = 32'h0000_0BAD;
    step();
    i_mem_ack = 1'b0;
    step();
    step();
    checks++;
    if (inst_acks - a0 !== 0 || data_acks - d0 !== 0 || o_mem_req !== 1'b0 || o_data_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_late_ack: got iacks=%0d dacks=%0d req=%b drdata=%h, want 0 0 0 0",
               inst_acks - a0, data_acks - d0, o_mem_req, o_data_rdata);
    end
    i_inst_req = 1'b1; i_inst_addr = 32'h0000_3000;
    serve(1, 32'h0000_0077, seen, addr, we);
    checks++;
    if (!seen || addr !== 32'h3000 || o_inst_ack !== 1'b1 || o_inst_rdata !== 32'h77) begin
      errors++;
      $display("FAIL rst_next_req: got seen=%b addr=%h iack=%b rdata=%h, want 1 3000 1 00000077",
               seen, addr, o_inst_ack, o_inst_rdata);
    end
    i_inst_req = 1'b0;
    step();
    step();
  endtask

  task automatic test_stray_ack();
    int          a0 = inst_acks;
    int          d0 = data_acks;
    bit          seen;
    logic [31:0] addr;
    logic        we;
    i_mem_ack = 1'b1; i_mem_rdata = 32'hFFFF_0000;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (o_mem_req !== 1'b0 || o_inst_ack !== 1'b0 || o_data_ack !== 1'b0) begin
        errors++;
        $display("FAIL stray_ack_idle: cycle %0d got req=%b iack=%b dack=%b, want 0 0 0",
                 i, o_mem_req, o_inst_ack, o_data_ack);
      end
    end
    i_mem_ack = 1'b0;
    step();
    checks++;
    if (inst_acks - a0 !== 0 || data_acks - d0 !== 0 || o_inst_rdata !== 32'h77 || o_data_rdata !== 32'h0) begin
      errors++;
      $display("FAIL stray_ack_state: got iacks=%0d dacks=%0d irdata=%h drdata=%h, want 0 0 00000077 0",
               inst_acks - a0, data_acks - d0, o_inst_rdata, o_data_rdata);
    end
    i_data_req = 1'b1; i_data_addr = 32'h0000_0080; i_data_we = 1'b0; i_data_width = 2'd2;
    step();
    checks++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h80) begin
      errors++;
      $display("FAIL stray_then_req: got req=%b addr=%h, want 1 80", o_mem_req, o_mem_addr);
    end
    serve(1, 32'hC0DE_0001, seen, addr, we);
    checks++;
    if (!seen || o_data_ack !== 1'b1 || o_data_rdata !== 32'hC0DE_0001) begin
      errors++;
      $display("FAIL stray_then_ack: got seen=%b dack=%b rdata=%h, want 1 1 c0de0001", seen, o_data_ack, o_data_rdata);
    end
    i_data_req = 1'b0;
    step();
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_inst_req = 1'b0; i_inst_addr = '0;
    i_data_req = 1'b0; i_data_addr = '0; i_data_wdata = '0;
    i_data_we = 1'b0; i_data_width = 2'd0; i_data_zeroextend = 1'b0;
    i_mem_ack = 1'b0; i_mem_rdata = '0;
    test_reset();
    test_inst_fetch();
    test_simultaneous();
    test_starvation();
    test_byte_load_stall();
    test_reset_busy();
    test_stray_ack();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within 200000 time units");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 3: the number of consecutive instruction-port losses after which the instruction port wins.
REQ-002 i_clk  in  1  single clock; all logic is clocked on the rising edge.
REQ-003 i_rst_n  in  1  reset; synchronous, active-low.
REQ-004 i_inst_req / i_inst_addr  in  1/32  instruction fetch request and word address.
REQ-005 o_inst_ack / o_inst_rdata  out  1/32  one-cycle completion pulse and fetched word.
REQ-006 i_data_req / i_data_addr / i_data_wdata  in  1/32/32  data request, address and store data.
REQ-007 i_data_we / i_data_width / i_data_zeroextend  in  1/2/1  store enable, access width (0=byte, 1=half, 2=word) and load zero-extend.
REQ-008 o_data_ack / o_data_rdata  out  1/32  one-cycle completion pulse and load data.
REQ-009 o_mem_req / o_mem_addr / o_mem_wdata / o_mem_we / o_mem_width / o_mem_zeroextend  out  1/32/32/1/2/1  single shared memory port.
REQ-010 i_mem_ack / i_mem_rdata  in  1/32  memory completion and read data; memory latency is at least 1 cycle after o_mem_req.

Function
REQ-011 The FSM SHALL have three states: IDLE, BUSY and RESP.
REQ-012 In IDLE with any request present, the block SHALL latch the winner's fields into o_mem_* and assert o_mem_req from the next cycle; the FSM SHALL go to BUSY.
REQ-013 Priority: data SHALL win over instruction, unless the starvation count equals STARVE_LIMIT and i_inst_req=1, in which case instruction SHALL win.
REQ-014 Starvation count (2-bit, saturating): it SHALL increment when data is granted while i_inst_req=1; it SHALL clear when instruction is granted.
REQ-015 For an instruction grant, o_mem_we SHALL be 0, o_mem_width SHALL be 2 and o_mem_zeroextend SHALL be 0.
REQ-016 o_mem_* fields SHALL stay stable while o_mem_req=1.
REQ-017 In BUSY, on i_mem_ack=1 the block SHALL drop o_mem_req at the next edge, register i_mem_rdata into the granted port's rdata, and go to RESP.
REQ-018 In RESP, exactly the granted port's ack SHALL be 1 for one cycle; no arbitration SHALL occur in RESP; the FSM SHALL return to IDLE.
REQ-019 A requester SHALL hold req and its fields until its ack; a req still high in the cycle after ack is a new transaction.
REQ-020 Minimum turnaround SHALL be 4 cycles from req sampled in IDLE to ack, with 1-cycle memory latency.
REQ-021 When both requests are present, the loser SHALL be served in the next IDLE without re-asserting its request.
REQ-022 i_mem_ack in IDLE or RESP SHALL be ignored.
REQ-023 o_inst_rdata and o_data_rdata SHALL hold their last value between acks.

Reset
REQ-024 While i_rst_n=0 at an edge, the block SHALL go to IDLE, clear the starvation count, and drive o_mem_req, o_inst_ack and o_data_ack to 0.
REQ-025 While i_rst_n=0 at an edge, the block SHALL clear o_mem_addr, o_mem_wdata, o_mem_we, o_mem_width, o_mem_zeroextend, o_inst_rdata and o_data_rdata to 0.
REQ-026 Reset mid-transaction SHALL abandon it: no ack is issued, and a late i_mem_ack is ignored per REQ-022.

Structure
REQ-027 A shared package SHALL hold the FSM state enum, the width encoding constants (BYTE/HALF/WORD), the port-select enum and the STARVE_LIMIT default.
REQ-028 The priority/starvation decision SHALL be a sub-module arb_pick: inputs are both reqs and the count; outputs are the grant select and the next count.

Verification
REQ-029 Instruction fetch alone: addr 0x10000000, memory acks 1 cycle after req with 0x00000013 -> o_inst_ack pulses once with o_inst_rdata=0x00000013, 4 cycles after req.
REQ-030 Simultaneous requests: data store addr 0x20, wdata 0xDEADBEEF, width 2 -> data is served first with o_mem_we=1; instruction is served next with no extra request; exactly one ack per port.
REQ-031 Starvation: data requests back-to-back for 5 transactions while the instruction request is held -> the instruction grant occurs after the 3rd data grant and the count returns to 0.
REQ-032 Load byte zero-extend: width 0, zeroextend 1 -> o_mem_width=0 and o_mem_zeroextend=1 remain stable across a 5-cycle memory stall.
REQ-033 Reset during BUSY followed by a late i_mem_ack -> no ack on either port and o_mem_req=0; the next request is served normally.
REQ-034 Stray i_mem_ack=1 in IDLE with no request -> no ack on either port and no state change.
